// File: rtl/ft245_device_emulator_pkg.sv
// Shared constants and FSM encodings for the FT245 device-side emulator.
package ft245_emu_pkg;
    localparam int BYTE_W          = 8;
    localparam int T_RD_CYC_DEF    = 5;
    localparam int T_PRECH_CYC_DEF = 3;

    typedef enum logic [1:0] {R_IDLE, R_AVAIL, R_DRIVE, R_PRECH} rx_state_e;
    typedef enum logic [1:0] {T_IDLE, T_READY, T_WAITHI, T_PRECH} tx_state_e;
endpackage

// File: rtl/ft245_device_emulator_if.sv
// FT245 parallel FIFO bus plus the load/drain side ports of the emulator.
// master = FPGA/host-model side, slave = emulated FT245 chip.
interface ft245_device_emulator_if;
    import ft245_emu_pkg::*;

    logic [BYTE_W-1:0] rx_data_245;
    logic              rxf_245;
    logic              rx_245;
    logic [BYTE_W-1:0] tx_data_245;
    logic              txe_245;
    logic              wr_245;
    logic              tx_oe_245;
    logic [BYTE_W-1:0] ld_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [BYTE_W-1:0] dr_data;
    logic              dr_valid;
    logic              dr_ready;
    logic              proto_err;

    modport slave (
        output rx_data_245, rxf_245, txe_245, ld_ready, dr_data, dr_valid, proto_err,
        input  rx_245, tx_data_245, wr_245, tx_oe_245, ld_data, ld_valid, dr_ready
    );

    modport master (
        input  rx_data_245, rxf_245, txe_245, ld_ready, dr_data, dr_valid, proto_err,
        output rx_245, tx_data_245, wr_245, tx_oe_245, ld_data, ld_valid, dr_ready
    );
endinterface

// File: rtl/ft245_device_emulator_sync_fifo.sv
// Registered-pointer synchronous FIFO; push+pop in one cycle allowed when non-empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/ft245_device_emulator.sv
// FT245 chip-side emulator: RX/TX FIFOs, RD#/WR# handshake FSMs, sticky protocol error.
// FT245_EMU_LOOPBACK_EN: route the TX FIFO head back into the RX FIFO.
//   state    | meaning
//   R_IDLE   | rxf high, waiting for a queued byte
//   R_AVAIL  | rxf low, waiting for RD# fall
//   R_DRIVE  | RD# low, data valid once the access counter expires
//   R_PRECH  | rxf held high after a read
//   T_IDLE   | txe high, waiting for TX space
//   T_READY  | txe low, waiting for WR# fall
//   T_WAITHI | byte taken, waiting for WR# rise
//   T_PRECH  | txe held high after a write
module ft245_device_emulator
    import ft245_emu_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int T_RD_CYC    = T_RD_CYC_DEF,
    parameter int T_PRECH_CYC = T_PRECH_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    ft245_device_emulator_if.slave bus
);
    rx_state_e         rx_st_q;
    tx_state_e         tx_st_q;
    logic              rx_q, rx_prev_q, wr_q, wr_prev_q;
    logic [BYTE_W-1:0] txd_q;
    logic [BYTE_W-1:0] rx_data_q;
    logic              rxf_q, txe_q, proto_err_q, rst_done_q;
    logic [7:0]        rd_cnt_q, rx_pre_q, tx_pre_q;

    logic              rd_fall, rd_rise, wr_fall, wr_rise;
    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [BYTE_W-1:0] rx_din, rx_head, tx_head;
    logic              ld_ready, ld_push, dr_valid;
    logic              rd_early, rd_bad, wr_bad, contention;

    assign rd_fall = rx_prev_q & ~rx_q;
    assign rd_rise = ~rx_prev_q & rx_q;
    assign wr_fall = wr_prev_q & ~wr_q;
    assign wr_rise = ~wr_prev_q & wr_q;

    assign rx_pop     = (rx_st_q == R_DRIVE) & rd_rise;
    assign rd_early   = rx_pop & (rd_cnt_q != 8'd0);
    assign rd_bad     = rd_fall & ((rx_st_q == R_IDLE) | (rx_st_q == R_PRECH));
    assign tx_push    = (tx_st_q == T_READY) & wr_fall;
    assign wr_bad     = wr_fall & (tx_st_q != T_READY);
    assign contention = bus.tx_oe_245 & ~rx_q;
    assign ld_ready   = rst_done_q & ~rx_full;

`ifdef FT245_EMU_LOOPBACK_EN
    logic lb_move;
    logic dr_ready_unused;
    assign dr_ready_unused = bus.dr_ready;

    always_comb begin
        ld_push  = bus.ld_valid & ld_ready;
        lb_move  = ~bus.ld_valid & rst_done_q & ~rx_full & ~tx_empty;
        rx_push  = ld_push | lb_move;
        rx_din   = ld_push ? bus.ld_data : tx_head;
        dr_valid = 1'b0;
        tx_pop   = lb_move;
    end
`else
    always_comb begin
        ld_push  = bus.ld_valid & ld_ready;
        rx_push  = ld_push;
        rx_din   = bus.ld_data;
        dr_valid = ~tx_empty;
        tx_pop   = dr_valid & bus.dr_ready;
    end
`endif

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push_i(rx_push), .data_i(rx_din), .pop_i(rx_pop),
        .data_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
    );

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push_i(tx_push), .data_i(txd_q), .pop_i(tx_pop),
        .data_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
    );

    // Strobes are registered once; tx data rides with WR# so the byte matches the detected fall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_q        <= 1'b1;
            rx_prev_q   <= 1'b1;
            wr_q        <= 1'b1;
            wr_prev_q   <= 1'b1;
            txd_q       <= '0;
            rst_done_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            rx_q       <= bus.rx_245;
            rx_prev_q  <= rx_q;
            wr_q       <= bus.wr_245;
            wr_prev_q  <= wr_q;
            txd_q      <= bus.tx_data_245;
            rst_done_q <= 1'b1;
            if (rd_early | rd_bad | wr_bad | contention) proto_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_st_q   <= R_IDLE;
            rxf_q     <= 1'b1;
            rx_data_q <= '0;
            rd_cnt_q  <= '0;
            rx_pre_q  <= '0;
        end else begin
            case (rx_st_q)
                R_IDLE: if (!rx_empty) begin
                    rx_st_q <= R_AVAIL;
                    rxf_q   <= 1'b0;
                end
                R_AVAIL: if (rd_fall) begin
                    rx_st_q  <= R_DRIVE;
                    rd_cnt_q <= 8'(T_RD_CYC);
                end
                R_DRIVE: begin
                    if (rd_rise) begin
                        rx_st_q   <= R_PRECH;
                        rxf_q     <= 1'b1;
                        rx_data_q <= '0;
                        rx_pre_q  <= 8'(T_PRECH_CYC);
                    end else if (rd_cnt_q != 8'd0) begin
                        rd_cnt_q <= rd_cnt_q - 8'd1;
                        if (rd_cnt_q == 8'd1) rx_data_q <= rx_head;
                    end
                end
                R_PRECH: begin
                    if (rx_pre_q <= 8'd1) rx_st_q <= R_IDLE;
                    else                  rx_pre_q <= rx_pre_q - 8'd1;
                end
                default: rx_st_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_st_q  <= T_IDLE;
            txe_q    <= 1'b1;
            tx_pre_q <= '0;
        end else begin
            case (tx_st_q)
                T_IDLE: if (!tx_full) begin
                    tx_st_q <= T_READY;
                    txe_q   <= 1'b0;
                end
                T_READY: if (wr_fall) begin
                    tx_st_q <= T_WAITHI;
                    txe_q   <= 1'b1;
                end
                T_WAITHI: if (wr_rise) begin
                    tx_st_q  <= T_PRECH;
                    tx_pre_q <= 8'(T_PRECH_CYC);
                end
                T_PRECH: begin
                    if (tx_pre_q <= 8'd1) tx_st_q <= T_IDLE;
                    else                  tx_pre_q <= tx_pre_q - 8'd1;
                end
                default: tx_st_q <= T_IDLE;
            endcase
        end
    end

    assign bus.rx_data_245 = rx_data_q;
    assign bus.rxf_245     = rxf_q;
    assign bus.txe_245     = txe_q;
    assign bus.ld_ready    = ld_ready;
    assign bus.dr_data     = tx_head;
    assign bus.dr_valid    = dr_valid;
    assign bus.proto_err   = proto_err_q;
endmodule
